// File: rtl/psg_attenuation_scheduler.sv
// Shares one attenuation lookup across the PSG channels: on each accepted sample tick the
// snapshotted channels are visited one per clock and their volumes summed into mix_out.
module psg_attenuation_scheduler #(
  parameter int CONTROL_BITS = 4,
  parameter int VOLUME_BITS  = 14,
  parameter int CHANNELS     = 4,
  localparam int IDX_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int MIX_W       = VOLUME_BITS + IDX_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    sample_tick,
  input  logic [CHANNELS-1:0]     channel_in,
  input  logic                    wr_en,
  input  logic [IDX_W-1:0]        wr_chan,
  input  logic [CONTROL_BITS-1:0] wr_value,
  output logic [MIX_W-1:0]        mix_out,
  output logic                    mix_valid,
  output logic                    busy,
  output logic                    overrun
);

  typedef enum logic {IDLE, ACC} state_t;

  localparam logic [IDX_W-1:0] LAST   = IDX_W'(CHANNELS - 1);
  localparam logic [IDX_W:0]   CH_LIM = (IDX_W + 1)'(CHANNELS);

  state_t                  state, state_nx;
  logic [IDX_W-1:0]        idx;
  logic [MIX_W-1:0]        acc;
  logic [CONTROL_BITS-1:0] att        [CHANNELS];
  logic [CONTROL_BITS-1:0] shadow_att [CHANNELS];
  logic [CHANNELS-1:0]     shadow_in;
  logic [VOLUME_BITS-1:0]  lut_out;
  logic [MIX_W-1:0]        term;

  // 2 dB per step, full scale 16383 at code 0, code 15 mutes.
  function automatic logic [VOLUME_BITS-1:0] atten_lut(input logic in,
                                                       input logic [CONTROL_BITS-1:0] code);
    int v;
    case (code)
      CONTROL_BITS'(0):  v = 16383;
      CONTROL_BITS'(1):  v = 13013;
      CONTROL_BITS'(2):  v = 10337;
      CONTROL_BITS'(3):  v = 8211;
      CONTROL_BITS'(4):  v = 6522;
      CONTROL_BITS'(5):  v = 5181;
      CONTROL_BITS'(6):  v = 4115;
      CONTROL_BITS'(7):  v = 3269;
      CONTROL_BITS'(8):  v = 2597;
      CONTROL_BITS'(9):  v = 2062;
      CONTROL_BITS'(10): v = 1638;
      CONTROL_BITS'(11): v = 1301;
      CONTROL_BITS'(12): v = 1034;
      CONTROL_BITS'(13): v = 821;
      CONTROL_BITS'(14): v = 652;
      default:           v = 0;
    endcase
    return in ? VOLUME_BITS'(v) : '0;
  endfunction

  assign lut_out = atten_lut(shadow_in[idx], shadow_att[idx]);
  assign term    = MIX_W'(lut_out);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (sample_tick) state_nx = ACC;
      ACC:     if (idx == LAST) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == ACC);
  end

  // Snapshot on accept; the sequence then reads only the shadow copies.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx       <= '0;
      acc       <= '0;
      mix_out   <= '0;
      mix_valid <= 1'b0;
      overrun   <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) att[i] <= '1;
    end else begin
      mix_valid <= 1'b0;
      overrun   <= 1'b0;
      if (wr_en && ({1'b0, wr_chan} < CH_LIM)) att[wr_chan] <= wr_value;
      case (state)
        IDLE: begin
          if (sample_tick) begin
            shadow_in <= channel_in;
            for (int i = 0; i < CHANNELS; i++) shadow_att[i] <= att[i];
            acc <= '0;
            idx <= '0;
          end
        end
        ACC: begin
          overrun <= sample_tick;
          if (idx == LAST) begin
            mix_out   <= acc + term;
            mix_valid <= 1'b1;
          end else begin
            acc <= acc + term;
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/psg_attenuation_scheduler.md
Name: psg_attenuation_scheduler

Overview:
- Time-multiplexes one instance of the team's `attenuation` lookup across the 4 PSG channels: 3 tone channels and 1 noise channel.
- Holds the four 4-bit attenuation registers and accepts register writes from the bus decoder.
- On each sample tick, sequences the channels through the shared lookup and accumulates their volumes into one mixed sample.
- Sits between the tone/noise generators and the audio output (PWM/DAC) stage.

Parameters:
- CONTROL_BITS, 4, attenuation code width per channel (15 = silent).
- VOLUME_BITS, 14, width of the lookup output per channel.
- CHANNELS, 4, number of channels sequenced; the index width is clog2(CHANNELS).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- sample_tick  input  1  one-cycle strobe requesting a new mixed sample.
- channel_in  input  CHANNELS  current 1-bit output of each generator; bit i belongs to channel i.
- wr_en  input  1  attenuation register write strobe.
- wr_chan  input  clog2(CHANNELS)  target channel of the write.
- wr_value  input  CONTROL_BITS  new attenuation code.
- mix_out  output  VOLUME_BITS+clog2(CHANNELS)  last completed mixed sample, held between updates.
- mix_valid  output  1  one-cycle pulse when mix_out updates.
- busy  output  1  high while the sequence is in progress (ACC state).
- overrun  output  1  one-cycle pulse when a sample_tick is dropped.

Behaviour:
- Reset values:
  - All attenuation registers = 4'hF (silent).
  - State = IDLE; channel index = 0; accumulator = 0.
  - mix_out = 0; mix_valid = 0; busy = 0; overrun = 0.
- Reset mid-sequence aborts the sequence. No mix_valid is produced for the aborted sample.
- Register writes:
  - A write with wr_en=1 updates att[wr_chan] at the clock edge.
  - Writes are accepted in any state.
  - A wr_chan value >= CHANNELS is ignored.
- Snapshot: when a tick is accepted, channel_in and all attenuation registers are copied into shadow registers.
  - The whole sequence uses only the shadow values.
  - Writes or input changes during ACC do not affect the sample in progress.
- Write and accepted tick in the same cycle: the snapshot takes the pre-write register value. The write is still applied to the live register.
- State machine:
  - IDLE: on sample_tick=1, take the snapshot, clear the accumulator, set index=0, go to ACC. busy=0.
  - ACC: one channel per clock.
    - Feed the shared lookup with in=shadow_in[index] and control=shadow_att[index].
    - Add the zero-extended lookup result to the accumulator.
    - When index = CHANNELS-1, register mix_out <= accumulator + this channel's term, pulse mix_valid, return to IDLE.
    - Otherwise increment the index.
    - busy=1 throughout ACC.
- Latency: for a tick sampled at edge T, mix_valid is high during the cycle following edge T+CHANNELS, i.e. edge T+4 with default parameters.
  - Minimum tick spacing is CHANNELS+1 cycles.
- Overrun: a sample_tick sampled while in ACC (including the final ACC cycle) is dropped and pulses overrun for one cycle.
  - The current sequence is unaffected.
- Arithmetic: unsigned, no saturation. The accumulator width VOLUME_BITS+clog2(CHANNELS) cannot overflow; the maximum is 4*16383 = 65532.
- Lookup table, VOLUME_BITS=14:
  - code 0 = 16383; code 1 = 13013; code 2 = 10337; code 15 = 0.
  - in=0 gives 0 regardless of the code.
- mix_out holds its value until the next completed sequence.

Test Plan:
- Reset, then one tick with channel_in=4'b1111 and no writes -> after 4 cycles, mix_valid pulses with mix_out=0 (all registers silent).
- Write att = {0,0,0,0}, channel_in=4'b1111, tick -> mix_out=65532, mix_valid exactly 4 cycles after the tick edge, busy high for 4 cycles.
- att0=0, att1=1, att2=2, att3=15, channel_in=4'b1111, tick -> mix_out = 16383+13013+10337+0 = 39733.
- Same registers, channel_in=4'b0101, tick -> mix_out = 16383+10337 = 26720.
- Tick and wr_en(chan 0, value 15) in the same cycle with att0=0 and channel_in=4'b0001 -> mix_out=16383. The next tick gives mix_out=0.
- Ticks 2 cycles apart -> second tick dropped with one overrun pulse and only one mix_valid.
- Separately, assert reset during the third ACC cycle -> no mix_valid, mix_out=0, busy=0 on the next cycle.
